// File: rtl/laser_job_sched.sv
// laser_job_sched
// Shares one two-circle laser coverage engine between two point-set
// requesters. A job of NPTS points is loaded from the granted lane into a
// local buffer. It is then replayed to the engine as one unbroken burst,
// straight after an engine reset pulse. The block waits for ENG_DONE under a
// watchdog and hands the two captured circle centres back through a
// valid/ready result port.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   IN_VALID[1:0]       per-lane point valid (lane i = requester i)
//   IN_XY[15:0]         lane i point at [8i+7:8i] = {X[3:0], Y[3:0]}
//   IN_READY[1:0]       per-lane point ready (only the granted lane, only in LOAD)
//   RES_VALID/RES_READY result handshake
//   RES_ID              requester owning the result
//   RES_ERR             1 = job aborted by the watchdog
//   RES_C1X..RES_C2Y    captured circle centres
//   BUSY                high whenever not idle
//   ENG_RST             registered engine reset, held while the engine is unused
//   ENG_X, ENG_Y        engine point inputs during the burst
//   ENG_DONE            engine completion pulse
//   ENG_C1X..ENG_C2Y    engine results, valid while ENG_DONE=1
module laser_job_sched #(
  parameter int NPTS    = 40,
  parameter int TIMEOUT = 262143
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  IN_VALID,
  input  logic [15:0] IN_XY,
  output logic [1:0]  IN_READY,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic        RES_ID,
  output logic        RES_ERR,
  output logic [3:0]  RES_C1X,
  output logic [3:0]  RES_C1Y,
  output logic [3:0]  RES_C2X,
  output logic [3:0]  RES_C2Y,
  output logic        BUSY,
  output logic        ENG_RST,
  output logic [3:0]  ENG_X,
  output logic [3:0]  ENG_Y,
  input  logic        ENG_DONE,
  input  logic [3:0]  ENG_C1X,
  input  logic [3:0]  ENG_C1Y,
  input  logic [3:0]  ENG_C2X,
  input  logic [3:0]  ENG_C2Y
);

  typedef enum logic [2:0] {IDLE, LOAD, ERST, STREAM, WAIT, RESULT} state_t;

  localparam logic [5:0]  LAST_PT  = 6'(NPTS - 1);
  localparam logic [19:0] WDOG_LIM = 20'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        g, g_nx;
  logic        last_id;
  logic [5:0]  cnt;
  logic [19:0] wdog;
  logic [7:0]  pt_buf [NPTS];
  logic [7:0]  lane_xy;
  logic        accept;

  assign lane_xy = g ? IN_XY[15:8] : IN_XY[7:0];
  assign accept  = (state == LOAD) && (g ? IN_VALID[1] : IN_VALID[0]);
  assign RES_ID  = g;

  // The burst is driven straight from the buffer so that point k is on the
  // engine inputs for the whole of STREAM cycle k.
  assign {ENG_X, ENG_Y} = (state == STREAM) ? pt_buf[cnt] : 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    g_nx      = g;
    IN_READY  = 2'b00;
    RES_VALID = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE: begin
        if (IN_VALID != 2'b00) begin
          state_nx = LOAD;
          // Single requester wins outright; a tie goes to the lane that
          // was not served last.
          g_nx = (IN_VALID == 2'b11) ? ~last_id : IN_VALID[1];
        end
      end
      LOAD: begin
        IN_READY = g ? 2'b10 : 2'b01;
        if (accept && cnt == LAST_PT) state_nx = ERST;
      end
      ERST:   state_nx = STREAM;
      STREAM: if (cnt == LAST_PT) state_nx = WAIT;
      WAIT:   if (ENG_DONE || wdog == WDOG_LIM) state_nx = RESULT;
      RESULT: begin
        RES_VALID = 1'b1;
        if (RES_READY) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      g       <= 1'b0;
      last_id <= 1'b1;
      cnt     <= 6'd0;
      wdog    <= 20'd0;
      ENG_RST <= 1'b1;
      RES_ERR <= 1'b0;
      RES_C1X <= 4'd0;
      RES_C1Y <= 4'd0;
      RES_C2X <= 4'd0;
      RES_C2Y <= 4'd0;
    end else begin
      g <= g_nx;
      // Registered from the next state so the engine leaves reset exactly
      // on the first burst cycle.
      ENG_RST <= (state_nx == IDLE) || (state_nx == LOAD) || (state_nx == ERST);
      case (state)
        IDLE: cnt <= 6'd0;
        LOAD: if (accept) cnt <= (cnt == LAST_PT) ? 6'd0 : cnt + 6'd1;
        ERST: cnt <= 6'd0;
        STREAM: begin
          if (cnt == LAST_PT) begin
            cnt  <= 6'd0;
            wdog <= 20'd0;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        WAIT: begin
          if (wdog != '1) wdog <= wdog + 20'd1;
          // DONE takes priority over a coinciding timeout.
          if (ENG_DONE) begin
            RES_ERR <= 1'b0;
            RES_C1X <= ENG_C1X;
            RES_C1Y <= ENG_C1Y;
            RES_C2X <= ENG_C2X;
            RES_C2Y <= ENG_C2Y;
          end else if (wdog == WDOG_LIM) begin
            RES_ERR <= 1'b1;
            RES_C1X <= 4'd0;
            RES_C1Y <= 4'd0;
            RES_C2X <= 4'd0;
            RES_C2Y <= 4'd0;
          end
        end
        RESULT: if (RES_READY) last_id <= g;
        default: ;
      endcase
    end
  end

  // Point buffer: data only, never reset.
  always_ff @(posedge CLK) begin
    if (accept) pt_buf[cnt] <= lane_xy;
  end

endmodule

// File: tb/tb_laser_job_sched.sv
// tb_laser_job_sched
// Directed bench for laser_job_sched: single job, load stalls, watchdog
// abort, result backpressure, reset in the middle of a burst and
// round-robin arbitration. A small engine model captures the burst.
module tb_laser_job_sched;
  localparam int NPTS    = 40;
  localparam int TIMEOUT = 600;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  IN_VALID;
  logic [15:0] IN_XY;
  logic [1:0]  IN_READY;
  logic        RES_VALID, RES_READY, RES_ID, RES_ERR;
  logic [3:0]  RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic        BUSY, ENG_RST;
  logic [3:0]  ENG_X, ENG_Y;
  logic        ENG_DONE;
  logic [3:0]  ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_pts [NPTS];
  logic [7:0] cap     [NPTS];
  int         sidx     = 0;
  logic       both_rdy = 1'b0;

  always #5 CLK = ~CLK;

  laser_job_sched #(.NPTS(NPTS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_XY(IN_XY),
    .IN_READY(IN_READY), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_ID(RES_ID), .RES_ERR(RES_ERR),
    .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y), .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y),
    .BUSY(BUSY), .ENG_RST(ENG_RST), .ENG_X(ENG_X), .ENG_Y(ENG_Y),
    .ENG_DONE(ENG_DONE),
    .ENG_C1X(ENG_C1X), .ENG_C1Y(ENG_C1Y), .ENG_C2X(ENG_C2X), .ENG_C2Y(ENG_C2Y)
  );

  // Engine model: after reset release it takes one point per cycle.
  always @(negedge CLK) begin
    if (ENG_RST) begin
      sidx <= 0;
    end else if (sidx < NPTS) begin
      cap[sidx] <= {ENG_X, ENG_Y};
      sidx      <= sidx + 1;
    end
    if (IN_READY == 2'b11) both_rdy <= 1'b1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({IN_READY, RES_VALID, RES_ID, RES_ERR, RES_C1X, RES_C1Y,
                RES_C2X, RES_C2Y, BUSY, ENG_RST, ENG_X, ENG_Y});
  endfunction

  task automatic fill(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < NPTS; i++) exp_pts[i] = base + 8'(i) * step;
  endtask

  // Called in an IDLE cycle with the requester valid already driven.
  task automatic arb(input string tag, input int lane);
    chk({tag, " idle"}, 32'(BUSY), 32'(0));
    tick();
    chk({tag, " grant"}, 32'(IN_READY), (lane == 1) ? 32'(2) : 32'(1));
    chk({tag, " engrst load"}, 32'(ENG_RST), 32'(1));
  endtask

  task automatic load(input string tag, input int lane, input bit gaps, input bit keep);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    bit  acc;
    while (i < NPTS && guard < 200) begin
      IN_VALID[lane]     = gaps ? ph : 1'b1;
      IN_XY[8*lane +: 8] = exp_pts[i];
      acc = IN_VALID[lane] && IN_READY[lane];
      tick();
      if (acc) i++;
      ph = ~ph;
      guard++;
    end
    IN_VALID[lane] = keep;
    chk({tag, " load count"}, 32'(i), 32'(NPTS));
  endtask

  // Called in the ERST cycle; returns in WAIT cycle 0.
  task automatic stream_chk(input string tag);
    int nbad = 0;
    chk({tag, " erst"}, 32'(ENG_RST), 32'(1));
    tick();
    chk({tag, " stream0 engrst"}, 32'(ENG_RST), 32'(0));
    repeat (NPTS) tick();
    for (int i = 0; i < NPTS; i++) if (cap[i] !== exp_pts[i]) nbad++;
    chk({tag, " burst len"}, 32'(sidx), 32'(NPTS));
    chk({tag, " burst data"}, 32'(nbad), 32'(0));
  endtask

  // Called in WAIT cycle 0; DONE is driven in WAIT cycle n.
  task automatic done_after(input string tag, input int n, input logic [15:0] c, input logic id);
    repeat (n) tick();
    ENG_DONE = 1'b1;
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = c;
    chk({tag, " pre valid"}, 32'(RES_VALID), 32'(0));
    tick();
    ENG_DONE = 1'b0;
    {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = ~c;
    chk({tag, " valid"}, 32'(RES_VALID), 32'(1));
    chk({tag, " result"}, 32'({RES_ID, RES_ERR, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}),
        32'({id, 1'b0, c}));
  endtask

  initial begin
    logic [31:0] snap;
    int          nbad;
    RST = 1'b1; IN_VALID = 2'b00; IN_XY = 16'h0; RES_READY = 1'b1;
    ENG_DONE = 1'b0; {ENG_C1X, ENG_C1Y, ENG_C2X, ENG_C2Y} = 16'h0;
    repeat (2) tick();
    chk("reset outputs", out_vec(), 32'h0000_0100);
    RST = 1'b0;

    // Single job on lane 0, DONE 500 cycles into WAIT.
    fill(8'h12, 8'h07);
    IN_VALID[0] = 1'b1;
    arb("jobA", 0);
    load("jobA", 0, 1'b0, 1'b0);
    stream_chk("jobA");
    done_after("jobA", 500, 16'h34AB, 1'b0);
    tick();
    chk("jobA accept idle", 32'({BUSY, RES_VALID}), 32'(0));

    // Lane 1 with valid toggling every other cycle.
    fill(8'hE1, 8'h0B);
    IN_VALID[1] = 1'b1;
    arb("stall", 1);
    load("stall", 1, 1'b1, 1'b0);
    stream_chk("stall");
    done_after("stall", 10, 16'h5C6D, 1'b1);
    tick();
    chk("stall accept idle", 32'({BUSY, RES_VALID}), 32'(0));

    // Watchdog: engine never answers.
    fill(8'h3C, 8'h05);
    IN_VALID[0] = 1'b1;
    arb("wdog", 0);
    load("wdog", 0, 1'b0, 1'b0);
    stream_chk("wdog");
    repeat (TIMEOUT - 1) tick();
    chk("wdog pre valid", 32'(RES_VALID), 32'(0));
    tick();
    chk("wdog valid", 32'(RES_VALID), 32'(1));
    chk("wdog result", 32'({RES_ID, RES_ERR, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}),
        32'({1'b0, 1'b1, 16'h0}));
    tick();
    chk("wdog accept idle", 32'({BUSY, RES_VALID}), 32'(0));

    // Result backpressure with lane 0 waiting.
    fill(8'h81, 8'h13);
    IN_VALID[1] = 1'b1;
    arb("bp", 1);
    load("bp", 1, 1'b0, 1'b0);
    stream_chk("bp");
    RES_READY   = 1'b0;
    IN_VALID[0] = 1'b1;
    done_after("bp", 3, 16'h1F2E, 1'b1);
    snap = out_vec();
    nbad = 0;
    repeat (20) begin
      tick();
      if (out_vec() !== snap || RES_VALID !== 1'b1 || IN_READY !== 2'b00) nbad++;
    end
    chk("bp hold stable", 32'(nbad), 32'(0));
    RES_READY = 1'b1;
    tick();
    fill(8'h07, 8'h09);
    arb("bp next", 0);
    load("bp next", 0, 1'b0, 1'b0);
    stream_chk("bp next");
    done_after("bp next", 2, 16'h7788, 1'b0);
    tick();
    chk("bp next accept idle", 32'({BUSY, RES_VALID}), 32'(0));

    // Reset at STREAM cycle 15.
    fill(8'hC0, 8'h03);
    IN_VALID[1] = 1'b1;
    arb("rst", 1);
    load("rst", 1, 1'b0, 1'b0);
    tick();
    repeat (15) tick();
    chk("rst stream15 busy", 32'({BUSY, ENG_RST}), 32'(2));
    RST = 1'b1;
    tick();
    chk("rst mid-stream outputs", out_vec(), 32'h0000_0100);
    RST = 1'b0;

    // Round robin from reset: grants 0, 1, 0.
    IN_VALID = 2'b11;
    for (int j = 0; j < 3; j++) begin
      fill(8'(j * 40 + 1), 8'h03);
      arb($sformatf("rr%0d", j), j % 2);
      load($sformatf("rr%0d", j), j % 2, 1'b0, 1'b1);
      stream_chk($sformatf("rr%0d", j));
      done_after($sformatf("rr%0d", j), 5, 16'h2468 + 16'(j), 1'(j % 2));
      tick();
    end
    IN_VALID = 2'b00;
    chk("ready never both", 32'(both_rdy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
